// File: rtl/instruction_mem_ldr_pkg.sv
// Shared definitions for the loadable instruction memory: controller state encoding
// and the default no-operation word.
package imem_pkg;

    typedef enum logic [1:0] {
        IMEM_CLEAR = 2'd0,
        IMEM_RUN   = 2'd1,
        IMEM_LOAD  = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // A fetch address is misaligned when it does not point at a word boundary.
    function automatic logic is_misaligned(input logic [1:0] byte_lsb);
        return (byte_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_mem_ldr_array.sv
// Instruction storage: DEPTH x DATA_W, one write port and one synchronous read port.
// The array has no reset; its contents are initialised by the clear sequence.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Write port and registered read port; read data holds when no read is issued.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data_r <= mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/instruction_mem_ldr.sv
// Loadable instruction memory for the fetch stage: clears to NOP after reset, accepts a
// sequential program load, and serves registered fetches with alignment/range fault flags.
module instruction_mem_ldr
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              fault_align,
    output logic              fault_range,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam int                WIDX_W   = ADDR_W - 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [WIDX_W-1:0] DEPTH_W  = WIDX_W'(DEPTH);

    imem_state_e       state_r;
    imem_state_e       state_s;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  ptr_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              load_done_s;

    logic [WIDX_W-1:0] word_idx_s;
    logic              align_s;
    logic              range_s;
    logic              fire_s;
    logic              rd_en_s;
    logic [DATA_W-1:0] rd_data_s;

    logic              fetch_valid_r;
    logic              fault_align_r;
    logic              fault_range_r;
    logic              nop_sel_r;
    logic              load_done_r;

    // State and write-pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IMEM_CLEAR;
            ptr_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
        end
    end

    // Next-state, pointer advance and array write control.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        wr_en_s     = 1'b0;
        wr_data_s   = NOP_WORD;
        load_done_s = 1'b0;
        case (state_r)
            IMEM_CLEAR: begin
                wr_en_s = 1'b1;
                if (ptr_r == LAST_IDX) begin
                    state_s = IMEM_RUN;
                    ptr_s   = {IDX_W{1'b0}};
                end else begin
                    ptr_s   = ptr_r + IDX_W'(1);
                end
            end
            IMEM_RUN: begin
                if (load_start) begin
                    state_s = IMEM_LOAD;
                    ptr_s   = {IDX_W{1'b0}};
                end else begin
                    state_s = IMEM_RUN;
                end
            end
            IMEM_LOAD: begin
                if (load_valid) begin
                    wr_en_s   = 1'b1;
                    wr_data_s = load_data;
                    // Terminal compare on the last index so the pointer never overflows.
                    if (load_last || (ptr_r == LAST_IDX)) begin
                        state_s     = IMEM_RUN;
                        ptr_s       = {IDX_W{1'b0}};
                        load_done_s = 1'b1;
                    end else begin
                        ptr_s = ptr_r + IDX_W'(1);
                    end
                end else begin
                    state_s = IMEM_LOAD;
                end
            end
            default: begin
                state_s = IMEM_CLEAR;
                ptr_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Fetch decode: faults are checked on the full word index, so no address wraps.
    always_comb begin
        word_idx_s = fetch_addr[ADDR_W-1:2];
        align_s    = is_misaligned(fetch_addr[1:0]);
        range_s    = (word_idx_s >= DEPTH_W);
        fire_s     = (state_r == IMEM_RUN) && fetch_req;
        rd_en_s    = fire_s && !align_s && !range_s;
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_idx  (ptr_r),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_idx  (word_idx_s[IDX_W-1:0]),
        .rd_data (rd_data_s)
    );

    // Fetch response and load-completion registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_valid_r <= 1'b0;
            fault_align_r <= 1'b0;
            fault_range_r <= 1'b0;
            nop_sel_r     <= 1'b1;
            load_done_r   <= 1'b0;
        end else begin
            fetch_valid_r <= fire_s;
            load_done_r   <= load_done_s;
            if (fire_s) begin
                fault_align_r <= align_s;
                fault_range_r <= range_s;
                nop_sel_r     <= align_s || range_s;
            end
        end
    end

    // A faulting fetch skips the array read, so the held read data is masked with NOP.
    assign instruction = nop_sel_r ? NOP_WORD : rd_data_s;
    assign fetch_valid = fetch_valid_r;
    assign fault_align = fault_align_r;
    assign fault_range = fault_range_r;
    assign load_done   = load_done_r;
    assign fetch_ready = (state_r == IMEM_RUN);
    assign load_ready  = (state_r == IMEM_LOAD);
    assign busy        = (state_r == IMEM_CLEAR) || (state_r == IMEM_LOAD);

endmodule
